// File: rtl/ctrl_act_arb.sv
// Round-robin arbiter sharing the GBFACT read port among the PEC clusters.
// Each grant issues BURST fetch pulses, then drains the read pipeline before re-arbitrating.
module ctrl_act_arb #(
  parameter int NUMPEC    = 48,
  parameter int BURST     = 16,
  parameter int FETCH_LAT = 3,
  localparam int IDW      = (NUMPEC > 1) ? $clog2(NUMPEC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              TOP_Sta,
  input  logic              TOP_Stp,
  input  logic [NUMPEC-1:0] PECCTRLACT_ReqAct,
  input  logic              GBFACT_Empty,
  output logic [NUMPEC-1:0] CTRLACTPEC_GntAct,
  output logic [IDW-1:0]    CTRLACT_IDPEC,
  output logic              CTRLACT_PlsFetch,
  output logic              CTRLACTPEC_VldAct,
  output logic              CTRLACT_Busy
);

  localparam int FCW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int DCW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDW-1:0]       ptr;
  logic [FCW-1:0]       fcnt;
  logic [DCW-1:0]       dcnt;
  logic                 stop_lat;
  logic [NUMPEC-1:0]    gnt;
  logic [IDW-1:0]       idpec;
  logic [FETCH_LAT-1:0] vld_pipe;

  logic                 win_found;
  logic [IDW-1:0]       win_idx;
  logic [IDW-1:0]       cand;
  logic [NUMPEC-1:0]    win_onehot;
  logic                 pls_fetch;
  logic                 last_fetch;
  logic                 drain_done;
  logic                 take_grant;

  // Search starts just after the last winner, so the previous owner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUMPEC; i++) begin
      cand = IDW'((int'(ptr) + i) % NUMPEC);
      if (!win_found && PECCTRLACT_ReqAct[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot = NUMPEC'(1) << win_idx;

  always_comb begin
    state_nxt  = state;
    pls_fetch  = (state == S_FETCH) && !GBFACT_Empty;
    last_fetch = pls_fetch && (fcnt == FCW'(BURST - 1));
    drain_done = (state == S_DRAIN) && (dcnt == DCW'(FETCH_LAT - 1));
    take_grant = (state == S_ARB) && !stop_lat && win_found;
    case (state)
      S_IDLE:  if (TOP_Sta) state_nxt = S_ARB;
      S_ARB: begin
        if (stop_lat)       state_nxt = S_IDLE;
        else if (win_found) state_nxt = S_FETCH;
      end
      S_FETCH: if (last_fetch) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done) state_nxt = S_ARB;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IDW'(NUMPEC - 1);
      gnt      <= '0;
      idpec    <= '0;
      fcnt     <= '0;
      dcnt     <= '0;
      stop_lat <= 1'b0;
    end else begin
      if (take_grant) begin
        gnt   <= win_onehot;
        idpec <= win_idx;
        ptr   <= win_idx;
      end else if (drain_done) begin
        gnt   <= '0;
        idpec <= '0;
      end
      if (last_fetch)     fcnt <= '0;
      else if (pls_fetch) fcnt <= fcnt + 1'b1;
      if (drain_done)              dcnt <= '0;
      else if (state == S_DRAIN)   dcnt <= dcnt + 1'b1;
      // A stop only takes effect at the next arbitration point, never mid-burst.
      if (state == S_ARB && stop_lat)       stop_lat <= 1'b0;
      else if (TOP_Stp && state != S_IDLE)  stop_lat <= 1'b1;
    end
  end

  // Delay line matching the GBFACT read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= pls_fetch;
      for (int i = 1; i < FETCH_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign CTRLACTPEC_GntAct = gnt;
  assign CTRLACT_IDPEC     = idpec;
  assign CTRLACT_PlsFetch  = pls_fetch;
  assign CTRLACTPEC_VldAct = vld_pipe[FETCH_LAT-1];
  assign CTRLACT_Busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ctrl_act_arb.sv
// Directed bench for ctrl_act_arb: default instance plus a BURST=1/FETCH_LAT=1 corner instance.
module tb_ctrl_act_arb;

  logic        clk;
  logic        rst_n;
  logic        sta, stp, empty;
  logic [47:0] req;
  logic [47:0] gnt;
  logic [5:0]  idpec;
  logic        pls, vld, busy;

  logic        sta_c, stp_c, empty_c;
  logic [47:0] req_c;
  logic [47:0] gnt_c;
  logic [5:0]  id_c;
  logic        pls_c, vld_c, busy_c;

  int tests_run;
  int tests_failed;

  ctrl_act_arb dut (
    .clk(clk), .rst_n(rst_n), .TOP_Sta(sta), .TOP_Stp(stp),
    .PECCTRLACT_ReqAct(req), .GBFACT_Empty(empty),
    .CTRLACTPEC_GntAct(gnt), .CTRLACT_IDPEC(idpec), .CTRLACT_PlsFetch(pls),
    .CTRLACTPEC_VldAct(vld), .CTRLACT_Busy(busy)
  );

  ctrl_act_arb #(.NUMPEC(48), .BURST(1), .FETCH_LAT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .TOP_Sta(sta_c), .TOP_Stp(stp_c),
    .PECCTRLACT_ReqAct(req_c), .GBFACT_Empty(empty_c),
    .CTRLACTPEC_GntAct(gnt_c), .CTRLACT_IDPEC(id_c), .CTRLACT_PlsFetch(pls_c),
    .CTRLACTPEC_VldAct(vld_c), .CTRLACT_Busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0; sta = 0; stp = 0; empty = 0; req = '0;
    sta_c = 0; stp_c = 0; empty_c = 0; req_c = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sta = 0; stp = 0; empty = 0; req = '0;
    sta_c = 0; stp_c = 0; empty_c = 0; req_c = '0;
    @(negedge clk);
    tests_run++; if (gnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_gnt: got %h expected 0", gnt); end
    tests_run++; if (idpec !== 6'd0) begin tests_failed++; $display("[TB] FAIL reset_id: got %0d expected 0", idpec); end
    tests_run++; if (pls !== 1'b0 || vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pls_vld: got %b%b expected 00", pls, vld); end
    tests_run++; if (busy !== 1'b0 || busy_c !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b%b expected 00", busy, busy_c); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1 req = 48'd1 << 5;
      @(negedge clk);
    end
    tests_run++; if (busy !== 1'b0 || gnt !== '0) begin tests_failed++; $display("[TB] FAIL idle_without_start: busy %b gnt %h expected 0 0", busy, gnt); end
  endtask

  // Measures the first grant window; win: 0 before, 1 inside, 2 after.
  task automatic test_single_requester();
    int win, glen, nf, nv, ff, fv, bad, orphan;
    logic [47:0] eg;
    win = 0; glen = 0; nf = 0; nv = 0; ff = -1; fv = -1; bad = 0; orphan = 0;
    eg = 48'd1 << 5;
    apply_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1 sta = (cyc == 0); req = eg;
      @(negedge clk);
      if (vld && gnt == '0) orphan++;
      if (win == 0 && gnt != '0) win = 1;
      else if (win == 1 && gnt == '0) win = 2;
      if (win == 1) begin
        glen++;
        if (gnt !== eg || idpec !== 6'd5) bad++;
        if (pls) begin nf++; if (ff < 0) ff = cyc; end
        if (vld) begin nv++; if (fv < 0) fv = cyc; end
      end
    end
    tests_run++; if (ff !== 2) begin tests_failed++; $display("[TB] FAIL single_first_fetch_cycle: got %0d expected 2", ff); end
    tests_run++; if (glen !== 19) begin tests_failed++; $display("[TB] FAIL single_grant_len: got %0d expected 19", glen); end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL single_gnt_id: got %0d bad cycles expected 0", bad); end
    tests_run++; if (nf !== 16) begin tests_failed++; $display("[TB] FAIL single_fetches: got %0d expected 16", nf); end
    tests_run++; if (nv !== 16) begin tests_failed++; $display("[TB] FAIL single_valids: got %0d expected 16", nv); end
    tests_run++; if (fv - ff !== 3) begin tests_failed++; $display("[TB] FAIL single_vld_latency: got %0d expected 3", fv - ff); end
    tests_run++; if (orphan !== 0) begin tests_failed++; $display("[TB] FAIL single_vld_without_gnt: got %0d expected 0", orphan); end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int gaps[$];
    int exp_ids[4];
    int zrun, multi;
    logic [47:0] prev;
    exp_ids = '{0, 47, 0, 47};
    zrun = 0; multi = 0; prev = '0;
    apply_reset();
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(posedge clk); #1 sta = (cyc == 0); req = (48'd1 << 0) | (48'd1 << 47);
      @(negedge clk);
      if ($countones(gnt) > 1) multi++;
      if (gnt != '0 && prev == '0) begin
        if (ids.size() > 0) gaps.push_back(zrun);
        ids.push_back(int'(idpec));
        zrun = 0;
      end
      if (gnt == '0) zrun++;
      prev = gnt;
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= ids.size() || ids[k] !== exp_ids[k]) begin
        tests_failed++;
        $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", k, (k < ids.size()) ? ids[k] : -1, exp_ids[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= gaps.size() || gaps[k] !== 1) begin
        tests_failed++;
        $display("[TB] FAIL rr_gap[%0d]: got %0d expected 1", k, (k < gaps.size()) ? gaps[k] : -1);
      end
    end
    tests_run++; if (multi !== 0) begin tests_failed++; $display("[TB] FAIL rr_onehot: got %0d multi-hot cycles expected 0", multi); end
  endtask

  // Empty high on even cycles: first FETCH cycle (2) stalls, so 16 fetches take 32 cycles.
  task automatic test_empty_stalls();
    int win, glen, nf, nv, clash;
    win = 0; glen = 0; nf = 0; nv = 0; clash = 0;
    apply_reset();
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk); #1 sta = (cyc == 0); req = 48'd1 << 12; empty = (cyc % 2 == 0);
      @(negedge clk);
      if (pls && empty) clash++;
      if (win == 0 && gnt != '0) win = 1;
      else if (win == 1 && gnt == '0) win = 2;
      if (win == 1) begin
        glen++;
        if (pls) nf++;
        if (vld) nv++;
      end
    end
    tests_run++; if (nf !== 16) begin tests_failed++; $display("[TB] FAIL stall_fetches: got %0d expected 16", nf); end
    tests_run++; if (nv !== 16) begin tests_failed++; $display("[TB] FAIL stall_valids: got %0d expected 16", nv); end
    tests_run++; if (glen !== 35) begin tests_failed++; $display("[TB] FAIL stall_grant_len: got %0d expected 35", glen); end
    tests_run++; if (clash !== 0) begin tests_failed++; $display("[TB] FAIL stall_fetch_while_empty: got %0d expected 0", clash); end
  endtask

  task automatic test_request_drop();
    int win, glen, nf;
    win = 0; glen = 0; nf = 0;
    apply_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1 sta = (cyc == 0); req = (cyc < 6) ? (48'd1 << 3) : '0;
      @(negedge clk);
      if (win == 0 && gnt != '0) win = 1;
      else if (win == 1 && gnt == '0) win = 2;
      if (win == 1) begin
        glen++;
        if (pls) nf++;
      end
    end
    tests_run++; if (nf !== 16) begin tests_failed++; $display("[TB] FAIL drop_fetches: got %0d expected 16", nf); end
    tests_run++; if (glen !== 19) begin tests_failed++; $display("[TB] FAIL drop_grant_len: got %0d expected 19", glen); end
    tests_run++; if (busy !== 1'b1 || gnt !== '0) begin tests_failed++; $display("[TB] FAIL drop_waits_in_arb: busy %b gnt %h expected 1 0", busy, gnt); end
  endtask

  // Grant 2..20, ARB at 21 with the stop latched, IDLE from 22 although the request stays high.
  task automatic test_stop();
    int late;
    logic [47:0] eg;
    late = 0;
    eg = 48'd1 << 7;
    apply_reset();
    for (int cyc = 0; cyc < 31; cyc++) begin
      @(posedge clk); #1 sta = (cyc == 0); stp = (cyc == 8); req = eg;
      @(negedge clk);
      if (cyc == 20) begin
        tests_run++; if (gnt !== eg) begin tests_failed++; $display("[TB] FAIL stop_burst_completes: got %h expected %h", gnt, eg); end
      end
      if (cyc == 21) begin
        tests_run++; if (gnt !== '0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL stop_arb_cycle: gnt %h busy %b expected 0 1", gnt, busy); end
      end
      if (cyc >= 22 && (busy || gnt != '0)) late++;
    end
    tests_run++; if (late !== 0) begin tests_failed++; $display("[TB] FAIL stop_idle: got %0d active cycles expected 0", late); end
  endtask

  task automatic test_reset_mid_burst();
    int nf;
    nf = 0;
    apply_reset();
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(posedge clk); #1 sta = (cyc == 0); req = 48'd1 << 9;
      if (cyc == 8) rst_n = 1'b0;
      @(negedge clk);
      if (cyc < 8 && pls) nf++;
    end
    tests_run++; if (nf !== 6) begin tests_failed++; $display("[TB] FAIL rstmid_prefetches: got %0d expected 6", nf); end
    tests_run++; if (gnt !== '0 || idpec !== 6'd0) begin tests_failed++; $display("[TB] FAIL rstmid_gnt: gnt %h id %0d expected 0 0", gnt, idpec); end
    tests_run++; if (pls !== 1'b0 || vld !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_outputs: pls %b vld %b busy %b expected 000", pls, vld, busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1 sta = 0; req = (48'd1 << 0) | (48'd1 << 9) | (48'd1 << 10);
      @(negedge clk);
    end
    tests_run++; if (busy !== 1'b0 || gnt !== '0) begin tests_failed++; $display("[TB] FAIL rstmid_waits_start: busy %b gnt %h expected 0 0", busy, gnt); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1 sta = (cyc == 0);
      @(negedge clk);
      if (cyc == 2) begin
        tests_run++; if (gnt !== 48'd1 || idpec !== 6'd0) begin tests_failed++; $display("[TB] FAIL rstmid_pec0_first: gnt %h id %0d expected 1 0", gnt, idpec); end
      end
    end
  endtask

  // BURST=1, FETCH_LAT=1: FETCH, DRAIN, ARB per grant, so grants rise every 3 cycles.
  task automatic test_corner_params();
    int ids[$];
    int rise[$];
    int wlen, wf, wv, bad_win, done_win, bad_period;
    logic [47:0] prev;
    wlen = 0; wf = 0; wv = 0; bad_win = 0; done_win = 0; bad_period = 0; prev = '0;
    apply_reset();
    for (int cyc = 0; cyc < 155; cyc++) begin
      @(posedge clk); #1 sta_c = (cyc == 0); req_c = '1;
      @(negedge clk);
      if (gnt_c != '0 && prev == '0) begin
        ids.push_back(int'(id_c));
        rise.push_back(cyc);
      end
      if (gnt_c != '0) begin
        wlen++;
        if (pls_c) wf++;
        if (vld_c) wv++;
      end else if (prev != '0) begin
        if (done_win < 49 && (wlen != 2 || wf != 1 || wv != 1)) bad_win++;
        done_win++;
        wlen = 0; wf = 0; wv = 0;
      end
      prev = gnt_c;
    end
    for (int k = 0; k < 49; k++) begin
      tests_run++;
      if (k >= ids.size() || ids[k] !== (k % 48)) begin
        tests_failed++;
        $display("[TB] FAIL corner_order[%0d]: got %0d expected %0d", k, (k < ids.size()) ? ids[k] : -1, k % 48);
      end
    end
    for (int k = 1; k < 49 && k < rise.size(); k++)
      if (rise[k] - rise[k-1] != 3) bad_period++;
    tests_run++; if (rise.size() < 49 || bad_period !== 0) begin tests_failed++; $display("[TB] FAIL corner_period: got %0d bad of %0d grants expected 0 of 49+", bad_period, rise.size()); end
    tests_run++; if (done_win < 49 || bad_win !== 0) begin tests_failed++; $display("[TB] FAIL corner_window: got %0d bad of %0d windows expected 0 of 49+", bad_win, done_win); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_empty_stalls();
    test_request_drop();
    test_stop();
    test_reset_mid_burst();
    test_corner_params();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ctrl_act_arb.md
# ctrl_act_arb

Round-robin controller that shares the single read port of the global activation buffer (GBFACT) among the `NUMPEC` processing-element clusters (PECs). It grants one requesting PEC at a time and issues a fixed-length burst of fetch pulses to GBFACT, stalling while the buffer is empty. It then drains the buffer read pipeline and hands the port to the next requester. It sits between GBFACT and the PEC array, alongside the weight controller.

## Interface
Parameters:
- `NUMPEC`, default 48: number of requesting PECs.
- `BURST`, default 16: activation words fetched per grant, legal range 1..256.
- `FETCH_LAT`, default 3: GBFACT read latency in cycles, from fetch pulse to data on the bus, legal range 1..8.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `TOP_Sta`, input, 1: start pulse, sampled only in IDLE.
- `TOP_Stp`, input, 1: stop request pulse, latched.
- `PECCTRLACT_ReqAct`, input, `NUMPEC`: per-PEC request level.
- `GBFACT_Empty`, input, 1: GBFACT has no readable word.
- `CTRLACTPEC_GntAct`, output, `NUMPEC`: one-hot grant, registered.
- `CTRLACT_IDPEC`, output, `C_LOG_2(NUMPEC)`: index of the granted PEC, registered.
- `CTRLACT_PlsFetch`, output, 1: read strobe to GBFACT.
- `CTRLACTPEC_VldAct`, output, 1: activation word valid to the granted PEC.
- `CTRLACT_Busy`, output, 1: high whenever state is not IDLE.

Reset values: every output is 0. The round-robin pointer resets to `NUMPEC-1`, all counters to 0, the stop latch to 0, and the state to IDLE.

## Operation
State machine:
- **IDLE**
  - `TOP_Sta`=1 → ARB. Otherwise stay.
- **ARB**
  - Stop latch set → IDLE, clear the latch.
  - Else if `|ReqAct` → FETCH. On this edge register `GntAct`/`IDPEC` for the winner and set the pointer to the winner.
  - Else stay.
- **FETCH**
  - `PlsFetch` = (state==FETCH) && !`GBFACT_Empty`, combinational.
  - Each pulse increments `fcnt`.
  - A pulse with `fcnt`==`BURST-1` → DRAIN, with `fcnt` cleared.
- **DRAIN**
  - `dcnt` counts 0..`FETCH_LAT-1`.
  - At `dcnt`==`FETCH_LAT-1` → ARB. On that edge clear `GntAct`, clear `IDPEC`, and clear `dcnt`.

Arbitration:
- Search indices `ptr+1`, `ptr+2`, … modulo `NUMPEC`. The first index with its request set wins.
- After reset PEC0 has the highest priority.
- A lone requester may be granted on consecutive bursts.

Valid pipeline:
- `VldAct` is `PlsFetch` delayed by exactly `FETCH_LAT` registers.
- DRAIN guarantees the last valid word arrives while the grant is still held.

Rules and boundaries:
- Request drop mid-burst: the burst still completes all `BURST` fetches. There is no abort.
- A granted PEC holds its request until its grant falls. Any re-assertion afterwards is treated as a new request.
- `TOP_Sta` outside IDLE is ignored.
- `TOP_Stp` in any non-IDLE state sets the stop latch. The current burst and drain complete, then ARB → IDLE.
- `GBFACT_Empty` high for any length of time in FETCH inserts bubbles only. `fcnt` holds.
- Reset asserted mid-burst: all outputs drop to 0 asynchronously and the pipeline flushes. Nothing is replayed.
- The pointer wraps from `NUMPEC-1` to 0.

## Timing
- Request-to-grant: request seen in ARB at cycle t → `GntAct` high at t+1 (first FETCH cycle).
- First `PlsFetch`: cycle t+1 if GBFACT is not empty.
- First `VldAct`: cycle t+1+`FETCH_LAT`.
- Burst length with no empty stalls: FETCH lasts `BURST` cycles and DRAIN lasts `FETCH_LAT` cycles. Grant is high for `BURST+FETCH_LAT` cycles.
- Back-to-back grants: one ARB cycle with grant low between bursts. Period is `BURST+FETCH_LAT+1` cycles.
- `GntAct` is one-hot or zero at all times. `VldAct` is never high while `GntAct`==0.

## Test plan
- **Reset, then start, single requester.** Reset, pulse `TOP_Sta`, hold `ReqAct`=1<<5, `Empty`=0 (defaults) →
  - `GntAct`=1<<5 and `IDPEC`=5 for 19 cycles;
  - 16 `PlsFetch` pulses;
  - 16 `VldAct` pulses, starting 3 cycles after the first fetch.
- **Round-robin fairness and wrap.** Requests {0, 47} held high → grant order 0, 47, 0, 47. Each grant is separated by one cycle with the grant low.
- **Empty stalls.** `Empty` high on every other cycle during FETCH → still exactly 16 fetches and 16 valids. Grant extends by the number of stall cycles.
- **Request drop and stop.**
  - `ReqAct` deasserted 4 cycles into a burst → the burst completes all 16 fetches.
  - `TOP_Stp` pulsed mid-burst → after DRAIN, one ARB cycle, then IDLE with `Busy`=0.
- **Reset mid-burst.** `rst_n` low at fetch 7 → `GntAct`, `PlsFetch`, `VldAct` and `Busy` are 0 immediately. After release the block waits for `TOP_Sta`, and PEC0 has first priority.
- **Parameter corner.** `BURST`=1, `FETCH_LAT`=1, all requests high → grants cycle through 0..47 and back to 0, with one fetch and one valid per grant and a 3-cycle grant period.
